multicycle_ctrl: RTL and testbench

Multi-cycle control unit that drives the single-issue RV32I subset datapath. It sequences each instruction through IF, ID, EX, MEM and WB states. It decodes the instruction word into the datapath control strobes: ALUSrc, ALUCtrl, MemToReg, RegWrite, PCSrc and loadPC. It also issues data-memory read/write strobes and holds in MEM until the data memory acknowledges.

---
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control unit for the RV32I subset datapath.
// Decode is combinational from instr; strobes are gated by the registered state.
module multicycle_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               ALUSrc,
    output logic [3:0]         ALUCtrl,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               PCSrc,
    output logic               loadPC,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        I_ILL,
        I_LW,
        I_SW,
        I_BEQ,
        I_ALU
    } iclass_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t     cur_state, nxt_state;
    logic       zero_q;
    iclass_t    iclass;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       is_reg, funct_ok;
    logic [3:0] alu_op;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_reg = (opcode == OP_REG);
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // Immediate forms carry immediate bits in funct7, so only shifts check it there.
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b0;
        case (funct3)
            3'b000: begin
                alu_op   = (is_reg && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                funct_ok = !is_reg || funct7 == F7_BASE || funct7 == F7_ALT;
            end
            3'b001: begin
                alu_op   = ALU_SLL;
                funct_ok = (funct7 == F7_BASE);
            end
            3'b010: begin
                alu_op   = ALU_SLT;
                funct_ok = !is_reg || funct7 == F7_BASE;
            end
            3'b100: begin
                alu_op   = ALU_XOR;
                funct_ok = !is_reg || funct7 == F7_BASE;
            end
            3'b101: begin
                alu_op   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                funct_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end
            3'b110: begin
                alu_op   = ALU_OR;
                funct_ok = !is_reg || funct7 == F7_BASE;
            end
            3'b111: begin
                alu_op   = ALU_AND;
                funct_ok = !is_reg || funct7 == F7_BASE;
            end
            default: begin
                alu_op   = ALU_ADD;
                funct_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        iclass = I_ILL;
        case (opcode)
            OP_LOAD:        if (funct3 == 3'b010) iclass = I_LW;
            OP_STORE:       if (funct3 == 3'b010) iclass = I_SW;
            OP_BRANCH:      if (funct3 == 3'b000) iclass = I_BEQ;
            OP_IMM, OP_REG: if (funct_ok)         iclass = I_ALU;
            default:        iclass = I_ILL;
        endcase
    end

    assign ALUSrc   = (iclass == I_LW) || (iclass == I_SW) || (iclass == I_ALU && !is_reg);
    assign ALUCtrl  = (iclass == I_BEQ) ? ALU_SUB :
                      (iclass == I_ALU) ? alu_op  : ALU_ADD;
    assign MemToReg = (iclass == I_LW);

    always_comb begin
        nxt_state = S_IF;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        PCSrc     = 1'b0;
        loadPC    = 1'b0;
        case (cur_state)
            S_IF:  nxt_state = S_ID;
            S_ID:  nxt_state = S_EX;
            S_EX:  nxt_state = S_MEM;
            S_MEM: begin
                MemRead   = (iclass == I_LW);
                MemWrite  = (iclass == I_SW);
                nxt_state = ((iclass == I_LW || iclass == I_SW) && !mem_ready) ? S_MEM : S_WB;
            end
            S_WB: begin
                loadPC    = 1'b1;
                RegWrite  = (iclass == I_LW) || (iclass == I_ALU);
                PCSrc     = (iclass == I_BEQ) && zero_q;
                nxt_state = S_IF;
            end
            default: nxt_state = S_IF;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IF;
            zero_q    <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_EX)
                zero_q <= Zero;
            else if (cur_state == S_IF)
                zero_q <= 1'b0;
        end
    end

    assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed vector table, reset corner
// cases and randomized instructions scored against a behavioural decode model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       alusrc;
        logic [3:0] aluctrl;
        logic       memtoreg;
        logic       regw;
        logic       rd;
        logic       wr;
        logic       beq;
    } dec_t;

    typedef struct {
        logic [31:0] ins;
        int          waits;
        logic        z_ex;
        logic        z_oth;
        logic        nm_ready;
        dec_t        d;
        logic        taken;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        Zero, mem_ready;
    logic        ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, PCSrc, loadPC;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
    logic [13:0] obs;

    int checks   = 0;
    int failures = 0;

    vec_t       vecs[$];
    logic [3:0] base_op [8];
    logic [3:0] alt_op  [8];

    multicycle_ctrl #(.STATE_W(3)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .PCSrc(PCSrc), .loadPC(loadPC),
        .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {state, ALUSrc, ALUCtrl, MemToReg, RegWrite, MemRead, MemWrite, PCSrc, loadPC};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {state, ALUSrc, ALUCtrl, MemToReg, RegWrite, MemRead, MemWrite, PCSrc, loadPC}.
    function automatic logic [13:0] exp_vec(input int st, input dec_t d, input logic taken);
        return {3'(st), d.alusrc, d.aluctrl, d.memtoreg,
                d.regw && st == 4, d.rd && st == 3, d.wr && st == 3, taken && st == 4, st == 4};
    endfunction

    // Decode model: opcode table, then funct3 lookup with a funct7-selected alternate op.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       f7_std, f7_alt, valid;
        logic [3:0] op;
        d      = '0;
        d.aluctrl = 4'b0010;
        f3     = w[14:12];
        f7     = w[31:25];
        f7_std = (f7 == 7'h00);
        f7_alt = (f7 == 7'h20);
        op     = (f7_alt && alt_op[f3] != 4'hF) ? alt_op[f3] : base_op[f3];
        valid  = 1'b0;
        case (w[6:0])
            7'h03: if (f3 == 3'd2) begin d.alusrc = 1; d.memtoreg = 1; d.regw = 1; d.rd = 1; end
            7'h23: if (f3 == 3'd2) begin d.alusrc = 1; d.wr = 1; end
            7'h63: if (f3 == 3'd0) begin d.aluctrl = 4'b0110; d.beq = 1; end
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) valid = f7_std || (f7_alt && alt_op[f3] != 4'hF);
                else                          valid = (f3 != 3'd3);
                if (f3 != 3'd5) op = base_op[f3];
                if (valid) begin d.alusrc = 1; d.regw = 1; d.aluctrl = op; end
            end
            7'h33: begin
                valid = (f7_std && f3 != 3'd3) || (f7_alt && alt_op[f3] != 4'hF);
                if (f7_std) op = base_op[f3];
                if (valid) begin d.regw = 1; d.aluctrl = op; end
            end
            default: ;
        endcase
        return d;
    endfunction

    task automatic add_vec(input logic [31:0] ins, input int waits, input logic z_ex,
                           input logic z_oth, input logic nm_ready, input logic as,
                           input logic [3:0] ac, input logic m2r, input logic rw,
                           input logic rd, input logic wr, input logic taken);
        vec_t v;
        v.ins = ins; v.waits = waits; v.z_ex = z_ex; v.z_oth = z_oth; v.nm_ready = nm_ready;
        v.d = '{alusrc: as, aluctrl: ac, memtoreg: m2r, regw: rw, rd: rd, wr: wr, beq: 1'b0};
        v.taken = taken;
        vecs.push_back(v);
    endtask

    // Entered just after a posedge with the DUT in IF; leaves just after the WB->IF edge.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int waits,
                             input logic z_ex, input logic z_oth, input logic nm_ready,
                             input dec_t d, input logic taken);
        int n_mem;
        n_mem = (d.rd || d.wr) ? waits + 1 : 1;
        for (int c = 0; c < n_mem + 4; c++) begin
            int st;
            if (c < 3)              st = c;
            else if (c < 3 + n_mem) st = 3;
            else                    st = 4;
            instr = ins;
            Zero  = (st == 2) ? z_ex : z_oth;
            if (st == 3 && (d.rd || d.wr)) mem_ready = (c - 3 >= waits);
            else                           mem_ready = nm_ready;
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), 32'(obs), 32'(exp_vec(st, d, taken)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] w;
        dec_t        d;
        logic        z_ex;

        base_op = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
        alt_op  = '{4'b0110, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1010, 4'hF, 4'hF};

        //      instr         waits zex zot nmr  as  aluctrl  m2r rw  rd  wr  taken
        add_vec(32'h00500093, 0,   0,  0,  0,   1,  4'b0010, 0,  1,  0,  0,  0); // ADDI
        add_vec(32'h0000A103, 3,   0,  0,  0,   1,  4'b0010, 1,  1,  1,  0,  0); // LW, 3 waits
        add_vec(32'h0020A223, 0,   0,  0,  1,   1,  4'b0010, 0,  0,  0,  1,  0); // SW
        add_vec(32'h00000463, 0,   1,  0,  0,   0,  4'b0110, 0,  0,  0,  0,  1); // BEQ taken
        add_vec(32'h00000463, 0,   0,  1,  0,   0,  4'b0110, 0,  0,  0,  0,  0); // BEQ not taken
        add_vec(32'h402081B3, 0,   0,  0,  1,   0,  4'b0110, 0,  1,  0,  0,  0); // SUB
        add_vec(32'hFFFFFFFF, 0,   1,  1,  1,   0,  4'b0010, 0,  0,  0,  0,  0); // ILLEGAL
        add_vec(32'h4030D093, 0,   0,  0,  0,   1,  4'b1010, 0,  1,  0,  0,  0); // SRAI
        add_vec(32'h0020C1B3, 0,   0,  0,  0,   0,  4'b1101, 0,  1,  0,  0,  0); // XOR
        add_vec(32'h00503093, 0,   0,  0,  0,   0,  4'b0010, 0,  0,  0,  0,  0); // SLTIU: illegal
        add_vec(32'h00001463, 0,   1,  1,  0,   0,  4'b0010, 0,  0,  0,  0,  0); // BNE: illegal
        add_vec(32'h40209133, 0,   0,  0,  0,   0,  4'b0010, 0,  0,  0,  0,  0); // SLL alt f7: illegal

        // Reset holds IF with every strobe low even while mem_ready and Zero are high.
        rst = 1'b1; instr = 32'h00000013; Zero = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), 32'(obs), 32'(14'b000_1_0010_0_00000));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i])
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].waits, vecs[i].z_ex,
                      vecs[i].z_oth, vecs[i].nm_ready, vecs[i].d, vecs[i].taken);

        // Reset during a LW memory wait, asserted together with mem_ready.
        instr = 32'h0000A103; Zero = 1'b0; mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rstmem_c%0d", c), 32'(obs), 32'(exp_vec(c < 3 ? c : 3, vecs[1].d, 1'b0)));
            @(posedge clk);
            #1;
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        check("rstmem_pre", 32'(obs), 32'(exp_vec(3, vecs[1].d, 1'b0)));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmem_post", 32'(obs), 32'(exp_vec(0, vecs[1].d, 1'b0)));
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ready = 1'b0;
        run_instr("after_rst_addi", vecs[0].ins, 0, 1'b0, 1'b0, 1'b0, vecs[0].d, 1'b0);

        for (int n = 0; n < 300; n++) begin
            int k;
            w = $urandom;
            k = $urandom_range(0, 5);
            case (k)
                0: begin w[6:0] = 7'h03; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
                1: begin w[6:0] = 7'h23; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd2; end
                2: begin w[6:0] = 7'h63; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
                3, 4: begin
                    w[6:0] = (k == 3) ? 7'h13 : 7'h33;
                    case ($urandom_range(0, 3))
                        0, 1: w[31:25] = 7'h00;
                        2:    w[31:25] = 7'h20;
                        default: ;
                    endcase
                end
                default: ;
            endcase
            d    = ref_decode(w);
            z_ex = 1'($urandom_range(0, 1));
            run_instr($sformatf("rnd%0d_%h", n, w), w, $urandom_range(0, 3), z_ex,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, d.beq && z_ex);
        end

        @(negedge clk);
        check("end_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
